ip_header_tx_gen: RTL

- Parametrised IPv4 header generator, next generation of the byte-serial IP header transmitter.
- Per request, latches header fields and computes the header checksum, then streams the 20-byte header (IHL=5, no options) MSB-first over a DATA_BYTES-wide stream with valid/ready backpressure.
- Adds over the previous generation:
  - configurable bus width;
  - arbitrary protocol number and TOS;
  - per-packet Identification counter;
  - DF flag option;
  - length-overflow rejection.
- Sits between the Ethernet header TX and the UDP/ICMP payload TX stages.

---
 rtl/ip_header_tx_gen_if.sv | 24 ++
 rtl/ip_header_tx_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ip_header_tx_gen_if.sv
// Header beat stream from the IPv4 header generator to the downstream TX stage.
// The first header byte on the wire occupies the MSBs of m_tdata.
interface ip_header_tx_gen_if #(
    parameter int unsigned DATA_BYTES = 1
);
    logic [8*DATA_BYTES-1:0] m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/ip_header_tx_gen.sv
// IPv4 header generator: latches a request, computes the header checksum and
// streams the 20-byte header (IHL=5) over a DATA_BYTES-wide valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for start; rejects over-length requests with len_err
// CALC   | adds header words W0..W9 (checksum word as 0) into the accumulator
// FOLD   | folds the accumulator carries and forms the checksum
// SEND   | streams header beats, advancing on each accepted beat
module ip_header_tx_gen #(
    parameter int unsigned DATA_BYTES = 1,
    parameter logic [7:0]  TTL        = 8'h40,
    parameter bit          DF         = 1'b1,
    parameter logic [15:0] ID_INIT    = 16'h0000
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               start,
    input  logic [7:0]         tos,
    input  logic [7:0]         protocol,
    input  logic [15:0]        payload_len,
    input  logic [31:0]        ip_s_addr,
    input  logic [31:0]        ip_d_addr,
    ip_header_tx_gen_if.master m_axis,
    output logic               busy,
    output logic               done,
    output logic               len_err
);

    if (DATA_BYTES != 1 && DATA_BYTES != 2 && DATA_BYTES != 4) begin : g_bad_width
        $error("ip_header_tx_gen: DATA_BYTES must be 1, 2 or 4");
    end

    localparam int unsigned BEAT_W      = 8 * DATA_BYTES;
    localparam int unsigned BEATS       = 20 / DATA_BYTES;
    localparam logic [4:0]  LAST_BEAT   = 5'(BEATS - 1);
    localparam logic [15:0] FLAGS_WORD  = DF ? 16'h4000 : 16'h0000;
    localparam logic [15:0] MAX_PAYLOAD = 16'd65515;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FOLD,
        S_SEND
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [19:0]   acc_q, acc_d;
    logic [7:0]    tos_q, tos_d;
    logic [7:0]    proto_q, proto_d;
    logic [15:0]   total_q, total_d;
    logic [15:0]   id_q, id_d;
    logic [15:0]   csum_q, csum_d;
    logic [31:0]   src_q, src_d;
    logic [31:0]   dst_q, dst_d;
    logic          done_q, done_d;
    logic          len_err_q, len_err_d;

    logic [15:0]   calc_word;
    logic [16:0]   fold1;
    logic [15:0]   fold2;
    logic [159:0]  hdr;
    logic [159:0]  hdr_sh;
    logic [7:0]    shamt;
    logic [BEAT_W-1:0] beat_data;
    logic          send_valid;
    logic          beat_acc;

    always_comb begin
        calc_word = 16'h0000;
        case (cnt_q)
            5'd0:    calc_word = {8'h45, tos_q};
            5'd1:    calc_word = total_q;
            5'd2:    calc_word = id_q;
            5'd3:    calc_word = FLAGS_WORD;
            5'd4:    calc_word = {TTL, proto_q};
            5'd6:    calc_word = src_q[31:16];
            5'd7:    calc_word = src_q[15:0];
            5'd8:    calc_word = dst_q[31:16];
            5'd9:    calc_word = dst_q[15:0];
            default: calc_word = 16'h0000;
        endcase
    end

    // Two folds suffice: the second add can no longer carry out of 16 bits.
    assign fold1 = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};
    assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

    assign hdr       = {8'h45, tos_q, total_q, id_q, FLAGS_WORD, TTL, proto_q,
                        csum_q, src_q, dst_q};
    assign shamt     = 8'(cnt_q) * 8'(BEAT_W);
    assign hdr_sh    = hdr << shamt;
    assign beat_data = hdr_sh[159 -: BEAT_W];

    assign send_valid = (state_q == S_SEND);
    assign beat_acc   = send_valid && m_axis.m_tready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        tos_d     = tos_q;
        proto_d   = proto_q;
        total_d   = total_q;
        id_d      = id_q;
        csum_d    = csum_q;
        src_d     = src_q;
        dst_d     = dst_q;
        done_d    = 1'b0;
        len_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The done cycle is IDLE, but a start landing on it is dropped.
                if (start && !done_q) begin
                    if (payload_len > MAX_PAYLOAD) begin
                        len_err_d = 1'b1;
                    end else begin
                        tos_d   = tos;
                        proto_d = protocol;
                        total_d = payload_len + 16'd20;
                        src_d   = ip_s_addr;
                        dst_d   = ip_d_addr;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_q + {4'b0, calc_word};
                if (cnt_q == 5'd9) begin
                    cnt_d   = '0;
                    state_d = S_FOLD;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_FOLD: begin
                csum_d  = ~fold2;
                cnt_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (beat_acc) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        id_d    = id_q + 16'd1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            tos_q     <= '0;
            proto_q   <= '0;
            total_q   <= '0;
            id_q      <= ID_INIT;
            csum_q    <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            tos_q     <= tos_d;
            proto_q   <= proto_d;
            total_q   <= total_d;
            id_q      <= id_d;
            csum_q    <= csum_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
        end
    end

    assign m_axis.m_tvalid = send_valid;
    assign m_axis.m_tdata  = send_valid ? beat_data : '0;
    assign m_axis.m_tlast  = send_valid && (cnt_q == LAST_BEAT);
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign len_err         = len_err_q;

endmodule
